// File: rtl/nova_csr_pkg.sv
// Shared definitions for the nova CSR block: register offsets (word index addr[7:2]),
// AXI-Lite response codes, CTRL bit positions and the address-map decode.
package nova_csr_pkg;

    localparam logic [5:0] OFF_ID       = 6'h00;
    localparam logic [5:0] OFF_SCRATCH  = 6'h01;
    localparam logic [5:0] OFF_CTRL     = 6'h02;
    localparam logic [5:0] OFF_IRQ_PEND = 6'h04;
    localparam logic [5:0] OFF_IRQ_MASK = 6'h05;
    localparam logic [5:0] OFF_CYC_LO   = 6'h06;
    localparam logic [5:0] OFF_CYC_HI   = 6'h07;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_SRST_BIT = 1;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_EXEC,
        WR_RESP
    } wr_state_t;

    // Anything above the 256-byte window, or a hole in the map, is unmapped.
    function automatic logic csr_mapped(input logic [31:0] addr);
        logic hit;
        hit = 1'b0;
        if (addr[31:8] == 24'h0) begin
            case (addr[7:2])
                OFF_ID, OFF_SCRATCH, OFF_CTRL, OFF_IRQ_PEND,
                OFF_IRQ_MASK, OFF_CYC_LO, OFF_CYC_HI: hit = 1'b1;
                default: hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

endpackage

// File: rtl/nova_csr_reg.sv
// Generic register with per-byte write strobes; holds the SCRATCH value.
module nova_csr_reg #(
    parameter int DATA_W = 32
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main_n,
    input  logic                  i_we,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_q <= '0;
        end else if (i_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (i_wstrb[b]) r_q[b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/nova_ocl_csr.sv
// AXI-Lite CSR slave: ID, SCRATCH, CTRL, IRQ pend/mask and an optional 64-bit cycle
// counter enabled by defining NOVA_OCL_CSR_CYCLE_CNT_EN.
module nova_ocl_csr
    import nova_csr_pkg::*;
#(
    parameter logic [31:0] ID_VAL = 32'hF001_1D0F
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    input  logic        event_i,
    output logic        enable_o,
    output logic        soft_rst_o,
    output logic        irq_o
);

    wr_state_t   r_wstate;
    logic        r_aw_held, r_w_held, r_awready, r_wready, r_bvalid;
    logic [1:0]  r_bresp;
    logic [31:0] r_awaddr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_arready, r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_enable, r_soft_rst, r_pend, r_mask, r_irq;

    logic        w_aw_hs, w_w_hs, w_ar_hs, w_wr_en, w_rd_ok;
    logic [5:0]  w_wr_off;
    logic [31:0] w_scratch, w_rd_data;

    assign w_aw_hs  = s_awvalid & r_awready;
    assign w_w_hs   = s_wvalid & r_wready;
    assign w_ar_hs  = s_arvalid & r_arready;
    assign w_wr_en  = (r_wstate == WR_EXEC) & csr_mapped(r_awaddr);
    assign w_wr_off = r_awaddr[7:2];

    // Write channel: AW and W park independently; the register update happens in EXEC.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_wstate  <= WR_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_wstate)
                WR_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr  <= s_awaddr;
                        r_aw_held <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= s_wdata;
                        r_wstrb  <= s_wstrb;
                        r_w_held <= 1'b1;
                    end
                    r_awready <= !(r_aw_held | w_aw_hs);
                    r_wready  <= !(r_w_held | w_w_hs);
                    if ((r_aw_held | w_aw_hs) && (r_w_held | w_w_hs)) r_wstate <= WR_EXEC;
                end
                WR_EXEC: begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= csr_mapped(r_awaddr) ? RESP_OKAY : RESP_SLVERR;
                    r_wstate <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_bready) begin
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= WR_IDLE;
                    end
                end
                default: r_wstate <= WR_IDLE;
            endcase
        end
    end

    nova_csr_reg #(.DATA_W(32)) u_scratch (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .i_we        (w_wr_en && (w_wr_off == OFF_SCRATCH)),
        .i_wstrb     (r_wstrb),
        .i_wdata     (r_wdata),
        .o_q         (w_scratch)
    );

    // Event set has priority over a same-cycle W1C so no interrupt is lost.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_enable   <= 1'b0;
            r_soft_rst <= 1'b0;
            r_pend     <= 1'b0;
            r_mask     <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_soft_rst <= 1'b0;
            if (w_wr_en && (w_wr_off == OFF_CTRL) && r_wstrb[0]) begin
                r_enable   <= r_wdata[CTRL_EN_BIT];
                r_soft_rst <= r_wdata[CTRL_SRST_BIT];
            end
            if (w_wr_en && (w_wr_off == OFF_IRQ_MASK) && r_wstrb[0]) r_mask <= r_wdata[0];
            if (event_i) r_pend <= 1'b1;
            else if (w_wr_en && (w_wr_off == OFF_IRQ_PEND) && r_wstrb[0] && r_wdata[0]) r_pend <= 1'b0;
            r_irq <= r_pend & r_mask;
        end
    end

`ifdef NOVA_OCL_CSR_CYCLE_CNT_EN
    logic [63:0] r_cyc;
    logic [31:0] r_cyc_snap;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_cyc      <= '0;
            r_cyc_snap <= '0;
        end else begin
            r_cyc <= r_cyc + 64'd1;
            if (w_ar_hs && w_rd_ok && (s_araddr[7:2] == OFF_CYC_LO)) r_cyc_snap <= r_cyc[63:32];
        end
    end
`endif

    always_comb begin
        w_rd_ok   = csr_mapped(s_araddr);
        w_rd_data = '0;
        case (s_araddr[7:2])
            OFF_ID:       w_rd_data = ID_VAL;
            OFF_SCRATCH:  w_rd_data = w_scratch;
            OFF_CTRL:     w_rd_data = {31'h0, r_enable};
            OFF_IRQ_PEND: w_rd_data = {31'h0, r_pend};
            OFF_IRQ_MASK: w_rd_data = {31'h0, r_mask};
`ifdef NOVA_OCL_CSR_CYCLE_CNT_EN
            OFF_CYC_LO:   w_rd_data = r_cyc[31:0];
            OFF_CYC_HI:   w_rd_data = r_cyc_snap;
`endif
            default:      w_rd_data = '0;
        endcase
        if (!w_rd_ok) w_rd_data = '0;
    end

    // Read data is captured at the AR handshake, so a same-cycle write is not visible.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && s_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end else begin
            r_arready <= !r_rvalid;
        end
    end

    assign s_awready  = r_awready;
    assign s_wready   = r_wready;
    assign s_bvalid   = r_bvalid;
    assign s_bresp    = r_bresp;
    assign s_arready  = r_arready;
    assign s_rvalid   = r_rvalid;
    assign s_rdata    = r_rdata;
    assign s_rresp    = r_rresp;
    assign enable_o   = r_enable;
    assign soft_rst_o = r_soft_rst;
    assign irq_o      = r_irq;

endmodule

// File: doc/nova_ocl_csr.md
NOVA_OCL_CSR -- requirements
Module: nova_ocl_csr

Interface
REQ-001 SHALL have parameter ID_VAL, default 32'hF001_1D0F; constant returned at register 0x00.
REQ-002 SHALL have port clk_main_a0  in  1  clock; all logic on its rising edge.
REQ-003 SHALL have port rst_main_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_awaddr  in  32  AXI-Lite write address.
REQ-005 SHALL have port s_awvalid  in  1  write address valid.
REQ-006 SHALL have port s_awready  out  1  write address ready.
REQ-007 SHALL have port s_wdata  in  32  write data.
REQ-008 SHALL have port s_wstrb  in  4  write byte strobes.
REQ-009 SHALL have port s_wvalid  in  1  write data valid.
REQ-010 SHALL have port s_wready  out  1  write data ready.
REQ-011 SHALL have port s_bresp  out  2  write response.
REQ-012 SHALL have port s_bvalid  out  1  write response valid.
REQ-013 SHALL have port s_bready  in  1  write response ready.
REQ-014 SHALL have port s_araddr  in  32  read address.
REQ-015 SHALL have port s_arvalid  in  1  read address valid.
REQ-016 SHALL have port s_arready  out  1  read address ready.
REQ-017 SHALL have port s_rdata  out  32  read data.
REQ-018 SHALL have port s_rresp  out  2  read response.
REQ-019 SHALL have port s_rvalid  out  1  read data valid.
REQ-020 SHALL have port s_rready  in  1  read data ready.
REQ-021 SHALL have port event_i  in  1  single-cycle interrupt event pulse.
REQ-022 SHALL have port enable_o  out  1  CTRL[0].
REQ-023 SHALL have port soft_rst_o  out  1  one-cycle soft-reset pulse.
REQ-024 SHALL have port irq_o  out  1  OR of IRQ_PEND & IRQ_MASK.

Function
REQ-025 SHALL decode registers on addr[7:2], with addr[31:8] nonzero or any undefined offset treated as unmapped: 0x00 ID (RO); 0x04 SCRATCH (RW, per-byte wstrb); 0x08 CTRL (bit0 enable RW, bit1 soft-reset write-1 self-clear, others read 0); 0x10 IRQ_PEND bit0 (W1C, byte0 strobe); 0x14 IRQ_MASK bit0 (RW); 0x18 CYC_LO; 0x1C CYC_HI.
REQ-026 SHALL accept AW and W independently into one-entry holding registers: awready=!aw_held, wready=!w_held, with bvalid low.
REQ-027 SHALL perform the write in the cycle after both are held, then assert bvalid with bresp 2'b00 (mapped) or 2'b10 (unmapped, no state change), hold both until bready, and clear both holds on the B handshake.
REQ-028 SHALL assert arready only when rvalid=0 and a read is not being accepted; rdata/rresp are registered and rvalid rises in the cycle after the AR handshake and holds until rready.
REQ-029 SHALL return rdata 32'h0 with rresp 2'b10 on an unmapped read.
REQ-030 SHALL assert soft_rst_o for exactly one cycle after a write of CTRL[1]=1, and CTRL[1] SHALL always read 0.
REQ-031 SHALL set IRQ_PEND on event_i, with set winning over a simultaneous W1C; irq_o SHALL be registered, so one cycle after the pend/mask update.
REQ-032 SHALL implement the cycle counter as 64-bit free-running, wrapping to 0 after 2^64-1; reading CYC_LO snapshots the upper 32 bits, and CYC_HI returns the snapshot.
REQ-033 SHALL handle simultaneous read and write to the same register by returning the pre-write value.

Reset
REQ-034 SHALL, on rst_main_n low: all registers, holds and counter 0; s_awready, s_wready, s_arready, s_bvalid, s_rvalid, enable_o, soft_rst_o, irq_o all 0; an in-flight transaction is dropped; ready outputs are re-enabled the first cycle after deassertion.

Configuration
REQ-035 SHALL, with NOVA_OCL_CSR_CYCLE_CNT_EN defined, include the counter and snapshot per REQ-032; without it, the counter logic SHALL be absent and CYC_LO/CYC_HI read 32'h0 with OKAY response.

Structure
REQ-036 SHALL place register offset localparams, bresp/rresp codes and the CTRL bit positions in shared package nova_csr_pkg.
REQ-037 SHALL implement the per-byte-strobe register as sub-module nova_csr_reg; the AXI-Lite FSM stays in the top module.

Verification
REQ-038 SHALL check: W 0x04=0xA5A5_1234 with wstrb 4'b0011, after a prior value of 0 -> read returns 0x0000_1234, bresp/rresp 00.
REQ-039 SHALL check: W issued 3 cycles before AW -> exactly one write, bvalid held 5 cycles with bready low, then a single handshake.
REQ-040 SHALL check: read 0x40 -> rdata 0, rresp 10; write 0x40 -> bresp 10, and all registers unchanged.
REQ-041 SHALL check: IRQ_MASK=1, then event_i pulses in the same cycle as a W1C to 0x10 -> IRQ_PEND stays 1 and irq_o stays 1; a later W1C -> irq_o 0 the next cycle.
REQ-042 SHALL check: CTRL write 0x3 -> enable_o=1, soft_rst_o high exactly 1 cycle, and a CTRL read returns 0x1.
REQ-043 SHALL check: reset asserted while bvalid is pending -> bvalid 0 immediately, and a read of SCRATCH after reset returns 0.
